// File: rtl/key_pio_edge_irq.sv
// Push-button PIO: synchronise, optionally debounce (KEY_PIO_DEBOUNCE_EN), per-channel edge detect,
// write-1-to-clear capture and masked level IRQ on an Avalon-MM slave.
module key_pio_edge_irq #(
    parameter int WIDTH       = 4,
    parameter int SYNC_STAGES = 2,
    parameter bit IDLE_LEVEL  = 1'b1,
    parameter int DEB_CYCLES  = 50000
) (
    input  logic             clk,
    input  logic             reset,
    input  logic [2:0]       address,
    input  logic             chipselect,
    input  logic             write_n,
    input  logic [31:0]      writedata,
    output logic [31:0]      readdata,
    output logic             irq,
    input  logic [WIDTH-1:0] in_port
);

    if (WIDTH < 1 || WIDTH > 16 || SYNC_STAGES < 2 || DEB_CYCLES < 1) begin : g_bad_param
        $error("key_pio_edge_irq: illegal parameter value");
    end

    localparam logic [WIDTH-1:0] IDLE_VEC = {WIDTH{IDLE_LEVEL}};

    logic [SYNC_STAGES-1:0][WIDTH-1:0] r_sync;
    logic [WIDTH-1:0]                  r_filt;
    logic [WIDTH-1:0]                  r_prev;
    logic [WIDTH-1:0]                  r_cap;
    logic [WIDTH-1:0]                  r_mask;
    logic [2*WIDTH-1:0]                r_mode;
    logic [31:0]                       r_readdata;

    logic [WIDTH-1:0] w_slast;
    logic [WIDTH-1:0] w_rise;
    logic [WIDTH-1:0] w_fall;
    logic [WIDTH-1:0] w_det;
    logic [WIDTH-1:0] w_clr;
    logic [31:0]      w_rd;
    logic             w_wr;
    logic             w_unused_ok;

    assign w_wr        = chipselect & ~write_n;
    assign w_slast     = r_sync[SYNC_STAGES-1];
    assign w_unused_ok = &{1'b0, writedata};

    always_ff @(posedge clk) begin
        if (reset) r_sync <= {SYNC_STAGES{IDLE_VEC}};
        else       r_sync <= {r_sync[SYNC_STAGES-2:0], in_port};
    end

`ifdef KEY_PIO_DEBOUNCE_EN
    localparam int CW = $clog2(DEB_CYCLES + 1);
    logic [WIDTH-1:0][CW-1:0] r_cnt;

    // filtered follows s_last only after DEB_CYCLES consecutive mismatching cycles
    always_ff @(posedge clk) begin
        if (reset) begin
            r_filt <= IDLE_VEC;
            r_cnt  <= '0;
        end else begin
            for (int i = 0; i < WIDTH; i++) begin
                if (w_slast[i] != r_filt[i]) begin
                    if (r_cnt[i] == CW'(DEB_CYCLES - 1)) begin
                        r_filt[i] <= w_slast[i];
                        r_cnt[i]  <= '0;
                    end else begin
                        r_cnt[i] <= r_cnt[i] + 1'b1;
                    end
                end else begin
                    r_cnt[i] <= '0;
                end
            end
        end
    end
`else
    always_ff @(posedge clk) begin
        if (reset) r_filt <= IDLE_VEC;
        else       r_filt <= w_slast;
    end
`endif

    assign w_rise = r_filt & ~r_prev;
    assign w_fall = ~r_filt & r_prev;

    always_comb begin
        w_det = '0;
        for (int i = 0; i < WIDTH; i++) begin
            case (r_mode[2*i +: 2])
                2'b00:   w_det[i] = w_rise[i];
                2'b01:   w_det[i] = w_fall[i];
                2'b10:   w_det[i] = w_rise[i] | w_fall[i];
                default: w_det[i] = 1'b0;
            endcase
        end
    end

    assign w_clr = (w_wr && address == 3'd3) ? writedata[WIDTH-1:0] : '0;

    always_ff @(posedge clk) begin
        if (reset) begin
            r_prev <= IDLE_VEC;
            r_cap  <= '0;
            r_mask <= '0;
            r_mode <= {WIDTH{2'b01}};
        end else begin
            r_prev <= r_filt;
            // set beats clear so an edge coinciding with a W1C is never lost
            r_cap  <= (r_cap & ~w_clr) | w_det;
            if (w_wr && address == 3'd2) r_mask <= writedata[WIDTH-1:0];
            if (w_wr && address == 3'd4) r_mode <= writedata[2*WIDTH-1:0];
        end
    end

    always_comb begin
        w_rd = '0;
        case (address)
            3'd0:    w_rd[WIDTH-1:0]   = r_filt;
            3'd2:    w_rd[WIDTH-1:0]   = r_mask;
            3'd3:    w_rd[WIDTH-1:0]   = r_cap;
            3'd4:    w_rd[2*WIDTH-1:0] = r_mode;
            default: w_rd = '0;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) r_readdata <= '0;
        else       r_readdata <= w_rd;
    end

    assign readdata = r_readdata;
    assign irq      = |(r_cap & r_mask);

endmodule

// File: tb/tb_key_pio_edge_irq.sv
// Directed self-checking bench for key_pio_edge_irq (WIDTH=4, SYNC_STAGES=2, DEB_CYCLES=4).
module tb_key_pio_edge_irq;

    logic        clk = 1'b0;
    logic        reset;
    logic [2:0]  address;
    logic        chipselect;
    logic        write_n;
    logic [31:0] writedata;
    logic [31:0] readdata;
    logic        irq;
    logic [3:0]  in_port;

    int total = 0;
    int bad   = 0;

    key_pio_edge_irq #(
        .WIDTH(4), .SYNC_STAGES(2), .IDLE_LEVEL(1'b1), .DEB_CYCLES(4)
    ) dut (
        .clk(clk), .reset(reset), .address(address), .chipselect(chipselect),
        .write_n(write_n), .writedata(writedata), .readdata(readdata),
        .irq(irq), .in_port(in_port)
    );

    always #5 clk = ~clk;

    task automatic cyc(input int n);
        for (int i = 0; i < n; i++) @(posedge clk);
        #1;
    endtask

    task automatic wr(input logic [2:0] a, input logic [31:0] d);
        @(posedge clk); #1;
        address = a; writedata = d; chipselect = 1'b1; write_n = 1'b0;
        @(posedge clk); #1;
        chipselect = 1'b0; write_n = 1'b1;
    endtask

    task automatic rd(input logic [2:0] a, output logic [31:0] d);
        @(posedge clk); #1;
        address = a; chipselect = 1'b1;
        @(posedge clk); #1;
        d = readdata; chipselect = 1'b0;
    endtask

    task automatic test_reset;
        logic [31:0] d;
        in_port = 4'hF; reset = 1'b1; address = 3'd0; chipselect = 1'b0;
        write_n = 1'b1; writedata = '0;
        cyc(2);
        total++; if (readdata !== 32'h0) begin bad++; $display("FAIL rst_readdata got=%h exp=0", readdata); end
        reset = 1'b0;
        for (int i = 0; i < 100; i++) begin
            cyc(1);
            total++; if (irq !== 1'b0) begin bad++; $display("FAIL rst_irq cyc=%0d got=%b exp=0", i, irq); end
        end
        rd(3'd0, d); total++; if (d !== 32'hF)  begin bad++; $display("FAIL rst_data got=%h exp=f", d); end
        rd(3'd3, d); total++; if (d !== 32'h0)  begin bad++; $display("FAIL rst_cap got=%h exp=0", d); end
        rd(3'd4, d); total++; if (d !== 32'h55) begin bad++; $display("FAIL rst_mode got=%h exp=55", d); end
        rd(3'd2, d); total++; if (d !== 32'h0)  begin bad++; $display("FAIL rst_mask got=%h exp=0", d); end
    endtask

    task automatic test_regs;
        logic [31:0] d;
        wr(3'd2, 32'hFFFF_FFFF);
        rd(3'd2, d); total++; if (d !== 32'hF) begin bad++; $display("FAIL mask_width got=%h exp=f", d); end
        wr(3'd0, 32'h0);
        rd(3'd0, d); total++; if (d !== 32'hF) begin bad++; $display("FAIL data_ro got=%h exp=f", d); end
        wr(3'd5, 32'hFFFF_FFFF);
        rd(3'd5, d); total++; if (d !== 32'h0) begin bad++; $display("FAIL addr5 got=%h exp=0", d); end
        rd(3'd1, d); total++; if (d !== 32'h0) begin bad++; $display("FAIL addr1 got=%h exp=0", d); end
        wr(3'd2, 32'h0);
    endtask

    task automatic test_falling;
        logic [31:0] d;
        wr(3'd2, 32'h1);
        in_port = 4'hE;             // sampled at next edge k
        cyc(3);                     // after k+2
        total++; if (irq !== 1'b0) begin bad++; $display("FAIL fall_early got=%b exp=0", irq); end
        cyc(1);                     // after k+3
        total++; if (irq !== 1'b1) begin bad++; $display("FAIL fall_irq got=%b exp=1", irq); end
        rd(3'd3, d); total++; if (d !== 32'h1) begin bad++; $display("FAIL fall_cap got=%h exp=1", d); end
        wr(3'd2, 32'h0);
        total++; if (irq !== 1'b0) begin bad++; $display("FAIL mask_drop got=%b exp=0", irq); end
        rd(3'd3, d); total++; if (d !== 32'h1) begin bad++; $display("FAIL cap_retain got=%h exp=1", d); end
        wr(3'd2, 32'h1);
        total++; if (irq !== 1'b1) begin bad++; $display("FAIL mask_raise got=%b exp=1", irq); end
        wr(3'd3, 32'h1);
        total++; if (irq !== 1'b0) begin bad++; $display("FAIL w1c_irq got=%b exp=0", irq); end
        rd(3'd3, d); total++; if (d !== 32'h0) begin bad++; $display("FAIL w1c_cap got=%h exp=0", d); end
        in_port = 4'hF;             // rising edge, ignored in falling mode
        cyc(6);
        rd(3'd3, d); total++; if (d !== 32'h0) begin bad++; $display("FAIL rise_ignored got=%h exp=0", d); end
        wr(3'd2, 32'h0);
    endtask

    task automatic test_mode_mix;
        logic [31:0] d;
        wr(3'd4, 32'hE4);
        rd(3'd4, d); total++; if (d !== 32'hE4) begin bad++; $display("FAIL mode_rb got=%h exp=e4", d); end
        rd(3'd3, d); total++; if (d !== 32'h0)  begin bad++; $display("FAIL mode_nochg got=%h exp=0", d); end
        in_port = 4'h0;
        cyc(6);
        rd(3'd3, d); total++; if (d !== 32'h6) begin bad++; $display("FAIL mix_fall got=%h exp=6", d); end
        rd(3'd0, d); total++; if (d !== 32'h0) begin bad++; $display("FAIL mix_data0 got=%h exp=0", d); end
        in_port = 4'hF;
        cyc(6);
        rd(3'd3, d); total++; if (d !== 32'h7) begin bad++; $display("FAIL mix_final got=%h exp=7", d); end
        wr(3'd3, 32'hF);
        rd(3'd3, d); total++; if (d !== 32'h0) begin bad++; $display("FAIL mix_clr got=%h exp=0", d); end
        wr(3'd4, 32'h55);
    endtask

    task automatic test_collision;
        logic [31:0] d;
        in_port = 4'hD;             // ch1 falls, sampled at edge k
        cyc(3);                     // after k+2: edge_detect[1] high until k+3
        address = 3'd3; writedata = 32'h2; chipselect = 1'b1; write_n = 1'b0;
        cyc(1);                     // write lands on k+3 together with the set
        chipselect = 1'b0; write_n = 1'b1;
        rd(3'd3, d); total++; if (d !== 32'h2) begin bad++; $display("FAIL collide got=%h exp=2", d); end
        wr(3'd3, 32'h0);
        rd(3'd3, d); total++; if (d !== 32'h2) begin bad++; $display("FAIL w0_noop got=%h exp=2", d); end
        wr(3'd3, 32'h2);
        rd(3'd3, d); total++; if (d !== 32'h0) begin bad++; $display("FAIL collide_clr got=%h exp=0", d); end
        in_port = 4'hF;
        cyc(12);
    endtask

`ifdef KEY_PIO_DEBOUNCE_EN
    task automatic test_debounce;
        logic [31:0] d;
        wr(3'd2, 32'h4);
        in_port = 4'hB; cyc(3); in_port = 4'hF;
        cyc(12);
        rd(3'd0, d); total++; if (d !== 32'hF) begin bad++; $display("FAIL glitch_data got=%h exp=f", d); end
        rd(3'd3, d); total++; if (d !== 32'h0) begin bad++; $display("FAIL glitch_cap got=%h exp=0", d); end
        address = 3'd0;
        in_port = 4'hB;             // sampled at k, s_last low after k+1, filtered at k+5
        cyc(6);                     // after k+5
        total++; if (readdata !== 32'hF) begin bad++; $display("FAIL deb_early got=%h exp=f", readdata); end
        total++; if (irq !== 1'b0) begin bad++; $display("FAIL deb_irq_early got=%b exp=0", irq); end
        cyc(1);                     // after k+6
        total++; if (readdata !== 32'hB) begin bad++; $display("FAIL deb_data got=%h exp=b", readdata); end
        total++; if (irq !== 1'b1) begin bad++; $display("FAIL deb_irq got=%b exp=1", irq); end
        wr(3'd3, 32'hF);
        wr(3'd2, 32'h0);
        in_port = 4'hF;
        cyc(12);
    endtask
`endif

    task automatic test_reset_mid;
        logic [31:0] d;
        wr(3'd2, 32'hF);
        in_port = 4'h5;
        cyc(8);
        rd(3'd3, d); total++; if (d !== 32'hA) begin bad++; $display("FAIL mid_cap got=%h exp=a", d); end
        in_port = 4'h4;             // ch0 falling in flight when reset hits
        cyc(3);
        reset = 1'b1; in_port = 4'hF;
        cyc(1);
        reset = 1'b0;
        total++; if (irq !== 1'b0) begin bad++; $display("FAIL mid_irq got=%b exp=0", irq); end
        cyc(20);
        total++; if (irq !== 1'b0) begin bad++; $display("FAIL mid_irq_late got=%b exp=0", irq); end
        rd(3'd3, d); total++; if (d !== 32'h0)  begin bad++; $display("FAIL mid_cap_rst got=%h exp=0", d); end
        rd(3'd2, d); total++; if (d !== 32'h0)  begin bad++; $display("FAIL mid_mask_rst got=%h exp=0", d); end
        rd(3'd0, d); total++; if (d !== 32'hF)  begin bad++; $display("FAIL mid_data got=%h exp=f", d); end
        rd(3'd4, d); total++; if (d !== 32'h55) begin bad++; $display("FAIL mid_mode got=%h exp=55", d); end
    endtask

    initial begin
        test_reset;
        test_regs;
        test_falling;
        test_mode_mix;
        test_collision;
`ifdef KEY_PIO_DEBOUNCE_EN
        test_debounce;
`endif
        test_reset_mid;
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/key_pio_edge_irq.md
Name: key_pio_edge_irq

Overview:
- Parametrised successor to the team's push-button input PIO on the Avalon-MM slave bus.
- Synchronises WIDTH external inputs and can debounce them.
- Detects a per-channel programmable edge type (rising/falling/any/off) and latches events into a write-1-to-clear capture register.
- Raises a level IRQ to the processor from the masked captures.

Parameters:
- WIDTH, 4, number of input channels; legal range 1..16.
- SYNC_STAGES, 2, synchroniser flops per channel; minimum 2.
- IDLE_LEVEL, 1, inactive input level; reset value of the synchroniser, filter and history flops.
- DEB_CYCLES, 50000, debounce stability window in clk cycles; minimum 1; used only with KEY_PIO_DEBOUNCE_EN.

Ports:
- clk  in  1  system clock; all logic on its rising edge.
- reset  in  1  synchronous, active-high reset.
- address  in  3  word address of the register.
- chipselect  in  1  slave select.
- write_n  in  1  active-low write strobe; a write occurs when chipselect=1 and write_n=0.
- writedata  in  32  write data.
- readdata  out  32  registered read data.
- irq  out  1  level interrupt.
- in_port  in  WIDTH  asynchronous external inputs (keys).

Behaviour:
- Reset: one clk with reset=1 sets the following.
  - readdata=0, irq_mask=0, edge_capture=0.
  - edge_mode = 01 for every channel (falling).
  - Sync chain, filtered, prev = {WIDTH{IDLE_LEVEL}}.
  - Debounce counters = 0.
- No spurious edge may follow reset.
- Reset mid-debounce or mid-capture discards all pending state.
- Register map (unused bits read 0, writes to them ignored):
  - 0 data: filtered[WIDTH-1:0]; read-only.
  - 2 irq_mask: bits [WIDTH-1:0]; read/write.
  - 3 edge_capture: bits [WIDTH-1:0]; read; write-1-to-clear per bit; written 0 bits unaffected.
  - 4 edge_mode: 2 bits per channel, channel i at [2i+1:2i].
    - 00 rising, 01 falling, 10 any, 11 disabled.
    - Read/write.
  - 1, 5, 6, 7: read 0; writes ignored.
- Read latency: readdata is registered every cycle from the current address. It is valid one clk after the address is presented and is independent of chipselect.
- Pipeline per channel:
  - s[0..SYNC_STAGES-1] <= in_port chain.
  - filtered <= s_last (or the debounced value).
  - prev <= filtered.
  - rise = filtered & ~prev; fall = ~filtered & prev.
  - edge_detect[i] is selected from rise/fall/either/0 by edge_mode[i].
- Capture:
  - edge_capture[i] <= 1 on edge_detect[i].
  - It clears on a write to address 3 with writedata[i]=1.
  - Simultaneous clear and edge on the same bit: set wins (the event is never lost).
- Latency without debounce: an in_port change first sampled at clk edge k sets edge_capture at edge k+SYNC_STAGES+1. It is readable SYNC_STAGES+2 edges after sampling.
- A mode change takes effect on the next cycle. Changing edge_mode never sets or clears capture bits by itself.
- irq = |(edge_capture & irq_mask), combinational from registers, so there is no glitch from in_port.
- Clearing the mask drops irq in the same cycle the register updates. The capture bits are retained.

Optional Feature:
- KEY_PIO_DEBOUNCE_EN defined:
  - Each channel has a counter of width clog2(DEB_CYCLES+1).
  - When s_last != filtered, the counter increments each cycle.
  - When s_last == filtered, the counter resets to 0.
  - filtered toggles, and the counter resets, on the cycle the mismatch has been seen for DEB_CYCLES consecutive cycles.
  - Glitches shorter than DEB_CYCLES cycles produce no data change and no edge.
  - Added latency: DEB_CYCLES-1 cycles.
- Macro undefined: no counters; filtered <= s_last every cycle; DEB_CYCLES is ignored.

Test Plan:
- Reset default: WIDTH=4, no debounce.
  - Hold in_port=4'hF, pulse reset.
  - Expect data=0xF, edge_capture=0, irq=0, edge_mode read=0x55 for 100 cycles.
- Falling edge and irq:
  - Write irq_mask=0x1. Drive in_port[0] 1->0.
  - Expect edge_capture=0x1 at sampling edge +3, irq=1.
  - Write 0x1 to addr 3: capture=0, irq=0.
- Mode mix:
  - Write edge_mode=0xE4 (ch0 rise, ch1 fall, ch2 any, ch3 off).
  - Toggle all inputs 1->0->1.
  - Expect ch0 capture only on the 0->1, ch1 only on the 1->0, ch2 on both, ch3 never. Final capture=0x7.
- Clear/set collision:
  - Time a write of 0x2 to addr 3 on the exact cycle edge_detect[1] fires.
  - Expect edge_capture[1]=1 afterwards.
  - Write 0x0 to addr 3: no bits change.
- Debounce (KEY_PIO_DEBOUNCE_EN, DEB_CYCLES=4):
  - A 3-cycle low glitch on in_port[2]: data stays 0xF, capture=0.
  - A sustained low: data[2]=0 exactly 4 cycles after s_last goes low, capture[2]=1 one cycle later.
- Reset mid-operation:
  - Assert reset while the debounce counter=2 and capture=0xA.
  - Expect counter=0, capture=0, mask=0, and no edge after release with in_port idle.
